// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending coin acceptor.
// Credit is counted in nickel units throughout.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'b00,
    ST_VEND   = 2'b01,
    ST_REFUND = 2'b10
  } state_t;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  function automatic logic [2:0] coin_value(
    input logic [1:0] code
  );
    logic [2:0] v;
    v = 3'd0;
    case (code)
      COIN_NICKEL:  v = 3'd1;
      COIN_DIME:    v = 3'd2;
      COIN_QUARTER: v = 3'd5;
      default:      v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Coin code to nickel-unit value and legality.
// Quarters are legal only when the build accepts them.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int ALLOW_QUARTER = 1
) (
  input  logic [1:0] coin,
  output logic [2:0] value,
  output logic       legal
);

  logic w_is_q;

  assign w_is_q = (coin == COIN_QUARTER);
  assign value  = coin_value(coin);
  assign legal  = (coin != COIN_NONE) &&
                  (!w_is_q || (ALLOW_QUARTER != 0));

endmodule

// File: rtl/vend_change_fsm.sv
// Coin acceptor: accumulate credit, vend at PRICE,
// then pay excess back as serial one-nickel pulses.
module vend_change_fsm
  import vend_pkg::*;
#(
  parameter int PRICE         = 3,
  parameter int CREDIT_W      = 4,
  parameter int ALLOW_QUARTER = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                newspaper,
  output logic                change,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  if ((1 << CREDIT_W) <= PRICE + 4) begin : g_bad_w
    $error("CREDIT_W too narrow for PRICE");
  end
  if (PRICE < 1 || PRICE > 31) begin : g_bad_p
    $error("PRICE out of range 1..31");
  end

  localparam logic [CREDIT_W:0] LP_PRICE =
    (CREDIT_W+1)'(PRICE);

  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic                  r_reject;
  logic [2:0]            w_value;
  logic                  w_legal;
  logic                  w_any;
  logic                  w_has;
  logic [CREDIT_W:0]     w_sum;

  vend_coin_decode #(
    .ALLOW_QUARTER(ALLOW_QUARTER)
  ) u_dec (
    .coin  (coin),
    .value (w_value),
    .legal (w_legal)
  );

  assign w_any = (coin != COIN_NONE);
  assign w_has = (r_credit != '0);
  assign w_sum = {1'b0, r_credit} +
                 (CREDIT_W+1)'(w_value);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_ACCEPT;
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      unique case (r_state)
        ST_ACCEPT: begin
          // cancel outranks any coin on the same edge
          if (cancel) begin
            r_reject <= w_any;
            if (w_has) r_state <= ST_REFUND;
          end else if (w_legal) begin
            if (w_sum >= LP_PRICE) begin
              r_credit <= CREDIT_W'(w_sum - LP_PRICE);
              r_state  <= ST_VEND;
            end else begin
              r_credit <= CREDIT_W'(w_sum);
            end
          end else begin
            r_reject <= w_any;
          end
        end
        ST_VEND: begin
          r_reject <= w_any;
          r_state  <= w_has ? ST_REFUND : ST_ACCEPT;
        end
        ST_REFUND: begin
          r_reject <= w_any;
          r_credit <= r_credit - CREDIT_W'(1);
          if (r_credit <= CREDIT_W'(1)) begin
            r_credit <= '0;
            r_state  <= ST_ACCEPT;
          end
        end
        default: begin
          r_state  <= ST_ACCEPT;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign newspaper   = (r_state == ST_VEND);
  assign change      = (r_state == ST_REFUND);
  assign busy        = (r_state != ST_ACCEPT);
  assign coin_reject = r_reject;
  assign credit      = r_credit;

endmodule

// File: tb/tb_vend_change_fsm.sv
// Bench for vend_change_fsm: quarter-accepting and
// quarter-rejecting builds run side by side against a model.
module tb_vend_change_fsm;

  logic       clock;
  logic       reset;
  logic [1:0] coin;
  logic       cancel;

  logic       a_nsp, a_chg, a_rej, a_busy;
  logic [3:0] a_cr;
  logic       b_nsp, b_chg, b_rej, b_busy;
  logic [3:0] b_cr;

  int n_chk = 0;
  int n_err = 0;

  vend_change_fsm #(
    .PRICE(3), .CREDIT_W(4), .ALLOW_QUARTER(1)
  ) dut (
    .clock(clock), .reset(reset), .coin(coin),
    .cancel(cancel), .newspaper(a_nsp), .change(a_chg),
    .coin_reject(a_rej), .busy(a_busy), .credit(a_cr)
  );

  vend_change_fsm #(
    .PRICE(3), .CREDIT_W(4), .ALLOW_QUARTER(0)
  ) dut_nq (
    .clock(clock), .reset(reset), .coin(coin),
    .cancel(cancel), .newspaper(b_nsp), .change(b_chg),
    .coin_reject(b_rej), .busy(b_busy), .credit(b_cr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    int credit;
    bit vend;
    bit refund;
    bit rej;
  } m_t;

  m_t ma, mb;

  // Abstract model: credit as an integer plus flags for
  // "vending now" and "paying out change".
  function automatic m_t mstep(m_t s, logic [1:0] c,
                               logic can, bit allowq,
                               int price);
    m_t n;
    int v;
    n = s;
    n.rej = 1'b0;
    v = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 :
        (c == 2'd3) ? 5 : 0;
    if (s.vend) begin
      n.vend   = 1'b0;
      n.refund = (s.credit > 0);
      n.rej    = (c != 2'd0);
    end else if (s.refund) begin
      n.credit = s.credit - 1;
      n.refund = (n.credit > 0);
      n.rej    = (c != 2'd0);
    end else if (can) begin
      n.rej    = (c != 2'd0);
      n.refund = (s.credit > 0);
    end else if (c == 2'd3 && !allowq) begin
      n.rej = 1'b1;
    end else if (v > 0) begin
      if (s.credit + v >= price) begin
        n.credit = s.credit + v - price;
        n.vend   = 1'b1;
      end else begin
        n.credit = s.credit + v;
      end
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = mstep(ma, coin, cancel, 1'b1, 3);
      mb = mstep(mb, coin, cancel, 1'b0, 3);
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      chk("a.newspaper", int'(a_nsp), int'(ma.vend));
      chk("a.change", int'(a_chg), int'(ma.refund));
      chk("a.busy", int'(a_busy),
          int'(ma.vend | ma.refund));
      chk("a.reject", int'(a_rej), int'(ma.rej));
      chk("a.credit", int'(a_cr), ma.credit);
      chk("b.newspaper", int'(b_nsp), int'(mb.vend));
      chk("b.change", int'(b_chg), int'(mb.refund));
      chk("b.busy", int'(b_busy),
          int'(mb.vend | mb.refund));
      chk("b.reject", int'(b_rej), int'(mb.rej));
      chk("b.credit", int'(b_cr), mb.credit);
    end
  end

  task automatic drive(logic [1:0] c, logic k);
    coin   = c;
    cancel = k;
    @(negedge clock);
  endtask

  initial begin
    coin   = 2'd0;
    cancel = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst.credit", int'(a_cr), 0);
    chk("rst.busy", int'(a_busy), 0);
    chk("rst.reject", int'(a_rej), 0);
    reset = 1'b0;

    // three nickels
    drive(2'd1, 1'b0);
    chk("n1.credit", int'(a_cr), 1);
    drive(2'd1, 1'b0);
    chk("n2.credit", int'(a_cr), 2);
    drive(2'd1, 1'b0);
    chk("n3.newspaper", int'(a_nsp), 1);
    chk("n3.credit", int'(a_cr), 0);
    drive(2'd0, 1'b0);
    chk("n3.idle.busy", int'(a_busy), 0);
    chk("n3.idle.change", int'(a_chg), 0);

    // single quarter: vend then two change pulses
    drive(2'd3, 1'b0);
    chk("q.newspaper", int'(a_nsp), 1);
    chk("q.credit", int'(a_cr), 2);
    chk("q.nq.reject", int'(b_rej), 1);
    drive(2'd0, 1'b0);
    chk("q.chg1", int'(a_chg), 1);
    drive(2'd0, 1'b0);
    chk("q.chg2", int'(a_chg), 1);
    chk("q.chg2.credit", int'(a_cr), 1);
    drive(2'd0, 1'b0);
    chk("q.done.change", int'(a_chg), 0);
    chk("q.done.credit", int'(a_cr), 0);

    // dime, cancel, dime during the refund
    drive(2'd2, 1'b0);
    chk("d.credit", int'(a_cr), 2);
    drive(2'd0, 1'b1);
    chk("c.change", int'(a_chg), 1);
    chk("c.newspaper", int'(a_nsp), 0);
    drive(2'd2, 1'b0);
    chk("c.reject", int'(a_rej), 1);
    chk("c.credit", int'(a_cr), 1);
    drive(2'd0, 1'b0);
    chk("c.end.change", int'(a_chg), 0);
    chk("c.end.credit", int'(a_cr), 0);

    // quarter rejected by the no-quarter build
    drive(2'd1, 1'b0);
    drive(2'd3, 1'b0);
    chk("nq.reject", int'(b_rej), 1);
    chk("nq.credit", int'(b_cr), 1);
    chk("aq.credit", int'(a_cr), 3);
    repeat (4) drive(2'd0, 1'b0);
    chk("aq.settled", int'(a_busy), 0);
    drive(2'd1, 1'b1);
    chk("nq.cancel.reject", int'(b_rej), 1);
    chk("nq.cancel.change", int'(b_chg), 1);
    chk("aq.cancel0.busy", int'(a_busy), 0);
    chk("aq.cancel0.reject", int'(a_rej), 1);
    drive(2'd0, 1'b0);
    chk("nq.cancel.done", int'(b_chg), 0);

    // reset in the middle of a 3-nickel refund
    drive(2'd1, 1'b0);
    drive(2'd3, 1'b0);
    drive(2'd0, 1'b0);
    chk("r.pre.change", int'(a_chg), 1);
    chk("r.pre.credit", int'(a_cr), 3);
    #2 reset = 1'b1;
    #1;
    chk("r.async.change", int'(a_chg), 0);
    chk("r.async.busy", int'(a_busy), 0);
    chk("r.async.credit", int'(a_cr), 0);
    @(negedge clock);
    reset = 1'b0;
    drive(2'd1, 1'b0);
    chk("r.after.credit", int'(a_cr), 1);
    drive(2'd0, 1'b0);
    repeat (3) drive(2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
